axis_fifo_param: RTL and testbench

AXIS_FIFO_PARAM -- requirements
Module: axis_fifo_param

---
 rtl/axis_pkg.sv | 23 ++
 rtl/axis_fifo_ram.sv | 25 ++
 rtl/axis_fifo_param.sv | 111 +++++++++++
 tb/tb_axis_fifo_param.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI-stream helpers: ceiling log2 for sizing and handshake constants.
package axis_pkg;

    // Handshake levels for valid/ready signals.
    localparam logic AXIS_HS_ACTIVE = 1'b1;
    localparam logic AXIS_HS_IDLE   = 1'b0;

    // Ceiling log2. A bounded loop keeps it usable as an elaboration-time constant.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // A beat transfers on an edge when both sides hold the handshake active.
    function automatic logic axis_fire(input logic valid, input logic ready);
        return (valid == AXIS_HS_ACTIVE) && (ready == AXIS_HS_ACTIVE);
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Storage behind the output register: registered write, asynchronous read.
// Contents are never reset; occupancy tracking lives in the parent.
module axis_fifo_ram #(
    parameter int WIDTH = 8,
    parameter int WORDS = 6,
    parameter int AW    = 3
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [WORDS];

    // Write port: one word per edge when enabled.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_fifo_param.sv
// AXI-stream FIFO: DEPTH-1 words of RAM feeding a registered output stage,
// so total capacity is DEPTH and every output is driven from flops.
module axis_fifo_param
    import axis_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 7,
    parameter  int AFULL  = DEPTH - 1,
    parameter  int AEMPTY = 1,
    localparam int CW     = clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic [WIDTH-1:0] idata,
    input  logic             ivalid,
    output logic             iready,
    output logic [WIDTH-1:0] odata,
    output logic             ovalid,
    input  logic             oready,
    output logic [CW-1:0]    size,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int RAMW = DEPTH - 1;
    localparam int AW   = (clog2(RAMW) < 1) ? 1 : clog2(RAMW);

    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CW-1:0]    r_size;
    logic             r_ovalid;
    logic             r_iready;
    logic [WIDTH-1:0] r_odata;

    logic             w_push, w_pop, w_ram_empty, w_load, w_ram_wr, w_ram_rd;
    logic [CW-1:0]    w_size_nxt;
    logic [WIDTH-1:0] w_ram_rdata;
    logic [AW-1:0]    w_wptr_inc, w_rptr_inc;

    assign w_push = axis_fire(ivalid, r_iready) & ~flush;
    assign w_pop  = axis_fire(r_ovalid, oready) & ~flush;

    // The output register is always filled before the RAM holds anything,
    // so RAM occupancy is size minus the output-stage valid bit.
    assign w_ram_empty = (r_size == CW'(r_ovalid));
    assign w_load      = ~r_ovalid | w_pop;
    assign w_ram_rd    = w_load & ~w_ram_empty;
    // A push into an empty pipe goes straight to the output register.
    assign w_ram_wr    = w_push & ~(w_load & w_ram_empty);

    assign w_size_nxt = r_size + CW'(w_push) - CW'(w_pop);

    // Pointers wrap at the RAM word count, which need not be a power of two.
    assign w_wptr_inc = (r_wptr == AW'(RAMW - 1)) ? '0 : r_wptr + AW'(1);
    assign w_rptr_inc = (r_rptr == AW'(RAMW - 1)) ? '0 : r_rptr + AW'(1);

    axis_fifo_ram #(
        .WIDTH (WIDTH),
        .WORDS (RAMW),
        .AW    (AW)
    ) u_ram (
        .i_clk   (clock),
        .i_we    (w_ram_wr),
        .i_waddr (r_wptr),
        .i_wdata (idata),
        .i_raddr (r_rptr),
        .o_rdata (w_ram_rdata)
    );

    // Pointers, occupancy, registered ready and the output stage.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_size   <= '0;
            r_ovalid <= 1'b0;
            r_iready <= 1'b0;
            r_odata  <= '0;
        end else if (flush) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_size   <= '0;
            r_ovalid <= 1'b0;
            r_iready <= 1'b1;
        end else begin
            r_size   <= w_size_nxt;
            r_iready <= (w_size_nxt < CW'(DEPTH));
            if (w_ram_wr) r_wptr <= w_wptr_inc;
            if (w_ram_rd) r_rptr <= w_rptr_inc;
            if (w_load) begin
                if (!w_ram_empty) begin
                    r_ovalid <= 1'b1;
                    r_odata  <= w_ram_rdata;
                end else if (w_push) begin
                    r_ovalid <= 1'b1;
                    r_odata  <= idata;
                end else begin
                    r_ovalid <= 1'b0;
                end
            end
        end
    end

    assign iready       = r_iready;
    assign ovalid       = r_ovalid;
    assign odata        = r_odata;
    assign size         = r_size;
    assign almost_full  = (r_size >= CW'(AFULL));
    assign almost_empty = (r_size <= CW'(AEMPTY));

endmodule

// File: tb/tb_axis_fifo_param.sv
// Bench: directed vector table and hand sequences on a DEPTH=7 instance,
// randomized traffic against a queue model on a DEPTH=5, WIDTH=16 instance.
module tb_axis_fifo_param;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // DEPTH=7, WIDTH=8 instance
    logic       fl7, iv7, or7;
    logic [7:0] d7;
    logic       ir7, ov7, af7, ae7;
    logic [7:0] od7;
    logic [2:0] sz7;

    // DEPTH=5, WIDTH=16 instance
    logic        fl5, iv5, or5;
    logic [15:0] d5;
    logic        ir5, ov5, af5, ae5;
    logic [15:0] od5;
    logic [2:0]  sz5;

    axis_fifo_param #(.WIDTH(8), .DEPTH(7)) dut7 (
        .clock(clk), .resetn(resetn), .flush(fl7), .idata(d7), .ivalid(iv7),
        .iready(ir7), .odata(od7), .ovalid(ov7), .oready(or7), .size(sz7),
        .almost_full(af7), .almost_empty(ae7)
    );

    axis_fifo_param #(.WIDTH(16), .DEPTH(5)) dut5 (
        .clock(clk), .resetn(resetn), .flush(fl5), .idata(d5), .ivalid(iv5),
        .iready(ir5), .odata(od5), .ovalid(ov5), .oready(or5), .size(sz5),
        .almost_full(af5), .almost_empty(ae5)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Full check of the DEPTH=7 instance; flags derive from size using AFULL=6, AEMPTY=1.
    task automatic chk7(input string tag, input logic e_ir, input logic e_ov,
                        input logic [7:0] e_od, input logic [2:0] e_sz);
        chk({tag, " iready"}, 32'(ir7), 32'(e_ir));
        chk({tag, " ovalid"}, 32'(ov7), 32'(e_ov));
        chk({tag, " size"},   32'(sz7), 32'(e_sz));
        chk({tag, " afull"},  32'(af7), 32'(e_sz >= 3'd6));
        chk({tag, " aempty"}, 32'(ae7), 32'(e_sz <= 3'd1));
        if (e_ov) chk({tag, " odata"}, 32'(od7), 32'(e_od));
    endtask

    task automatic step7(input logic fl, input logic iv, input logic [7:0] d, input logic ordy);
        fl7 = fl; iv7 = iv; d7 = d; or7 = ordy;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        logic [2:0] e_sz;
    } vec_t;

    function automatic vec_t mk(logic fl, logic iv, logic [7:0] d, logic ordy,
                                logic e_ir, logic e_ov, logic [7:0] e_od, logic [2:0] e_sz);
        vec_t v;
        v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_sz = e_sz;
        return v;
    endfunction

    vec_t tbl[$];
    logic [15:0] q[$];
    int max_sz = 0;
    int pops = 0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Each entry: inputs for one edge, expected outputs after that edge.
        for (int k = 1; k <= 7; k++)
            tbl.push_back(mk(0, 1, 8'(k), 0, (k < 7), 1, 8'd1, 3'(k)));
        tbl.push_back(mk(0, 1, 8'd99, 0, 0, 1, 8'd1, 3'd7));   // full: push refused
        tbl.push_back(mk(0, 1, 8'd99, 1, 1, 1, 8'd2, 3'd6));   // pop at full, push still refused
        for (int k = 2; k <= 6; k++)
            tbl.push_back(mk(0, 0, 8'd0, 1, 1, 1, 8'(k + 1), 3'(7 - k)));
        tbl.push_back(mk(0, 0, 8'd0, 1, 1, 0, 8'd0, 3'd0));
        tbl.push_back(mk(0, 1, 8'd10, 0, 1, 1, 8'd10, 3'd1));
        tbl.push_back(mk(0, 1, 8'd11, 0, 1, 1, 8'd10, 3'd2));
        tbl.push_back(mk(0, 1, 8'd12, 0, 1, 1, 8'd10, 3'd3));
        tbl.push_back(mk(1, 1, 8'd13, 1, 1, 0, 8'd0, 3'd0));   // flush drops all plus 13
        tbl.push_back(mk(0, 1, 8'd14, 0, 1, 1, 8'd14, 3'd1));
        tbl.push_back(mk(0, 1, 8'd15, 1, 1, 1, 8'd15, 3'd1));  // push+pop at size 1
        tbl.push_back(mk(0, 0, 8'd0, 1, 1, 0, 8'd0, 3'd0));

        // Reset: outputs take reset values with no clock edge involved.
        resetn = 1'b0;
        fl7 = 0; iv7 = 0; d7 = 0; or7 = 0;
        fl5 = 0; iv5 = 0; d5 = 0; or5 = 0;
        #1;
        chk7("reset", 0, 0, 8'd0, 3'd0);
        chk("reset odata", 32'(od7), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("iready before first edge", 32'(ir7), 32'd0);
        @(posedge clk); #1;
        chk7("post-reset edge", 1, 0, 8'd0, 3'd0);

        // Directed table.
        foreach (tbl[i]) begin
            step7(tbl[i].fl, tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk7($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_od, tbl[i].e_sz);
        end

        // Streaming: one word per cycle after one cycle of latency, size pinned at 1.
        for (int k = 0; k < 10; k++) begin
            step7(0, 1, 8'(20 + k), 1);
            chk7($sformatf("stream%0d", k), 1, 1, 8'(20 + k), 3'd1);
        end
        step7(0, 0, 8'd0, 1);
        chk7("stream drain", 1, 0, 8'd0, 3'd0);

        // Reset pulsed mid-stream.
        step7(0, 1, 8'd40, 0);
        step7(0, 1, 8'd41, 0);
        step7(0, 1, 8'd42, 0);
        chk7("pre-pulse", 1, 1, 8'd40, 3'd3);
        iv7 = 0;
        #3;
        resetn = 1'b0;
        #1;
        chk7("async reset", 0, 0, 8'd0, 3'd0);
        chk("async reset odata", 32'(od7), 32'd0);
        #2;
        resetn = 1'b1;
        @(posedge clk); #1;
        chk7("after pulse idle", 1, 0, 8'd0, 3'd0);
        step7(0, 1, 8'd50, 0);
        chk7("after pulse push", 1, 1, 8'd50, 3'd1);
        step7(0, 0, 8'd0, 1);
        chk7("after pulse pop", 1, 0, 8'd0, 3'd0);
        step7(0, 0, 8'd0, 0);

        // Random traffic on DEPTH=5 against a queue: pushes land at the tail,
        // pops take the head, flush empties it, capacity is 5.
        for (int c = 0; c < 1000; c++) begin
            bit fill_phase;
            bit m_push, m_pop;
            fill_phase = ((c / 100) % 2) == 0;
            iv5 = ($urandom_range(0, 99) < (fill_phase ? 75 : 35));
            or5 = ($urandom_range(0, 99) < (fill_phase ? 35 : 75));
            fl5 = ($urandom_range(0, 63) == 0);
            d5  = 16'($urandom);
            m_push = iv5 && (q.size() < 5) && !fl5;
            m_pop  = (q.size() > 0) && or5 && !fl5;
            @(posedge clk); #1;
            if (fl5) q.delete();
            else begin
                if (m_pop) begin
                    void'(q.pop_front());
                    pops++;
                end
                if (m_push) q.push_back(d5);
            end
            if (int'(sz5) > max_sz) max_sz = int'(sz5);
            chk($sformatf("rnd%0d size", c),   32'(sz5), 32'(q.size()));
            chk($sformatf("rnd%0d ovalid", c), 32'(ov5), 32'(q.size() > 0));
            chk($sformatf("rnd%0d iready", c), 32'(ir5), 32'(q.size() < 5));
            chk($sformatf("rnd%0d afull", c),  32'(af5), 32'(q.size() >= 4));
            chk($sformatf("rnd%0d aempty", c), 32'(ae5), 32'(q.size() <= 1));
            if (q.size() > 0) chk($sformatf("rnd%0d odata", c), 32'(od5), 32'(q[0]));
        end
        iv5 = 0; or5 = 0; fl5 = 0;
        chk("rnd max size", 32'(max_sz), 32'd5);
        chk("rnd enough pops", 32'(pops > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
